ras_spec_ckpt: RTL and testbench
================================

// Module: ras_spec_ckpt
// PURPOSE
// - Next-gen return address stack for the fetch-stage predictor: circular buffer with TOS pointer and occupancy count.
// - Adds overflow wrap (oldest entry overwritten) and underflow detect.
// - Adds checkpoint/restore so wrong-path calls and returns are repaired on branch mispredict.
// - Sits between the predecoder (push/pop) and the next-PC mux (top_o). Restore is driven from the branch resolution unit.
// PARAMETERS
// - DEPTH  default bmm_pkg::RAS_DEPTH (8)  entries; power of 2, >=2. Elaboration assert DEPTH==bmm_pkg::RAS_DEPTH.
// - XLEN   default 32                      return address width.
// PORTS
// - clk_i            in   1                clock; single clock domain.
// - rst_ni           in   1                reset, synchronous, active-low.
// - flush_i          in   1                discard all stack contents (pipeline flush).
// - push_i           in   1                call predicted this cycle.
// - pop_i            in   1                return predicted this cycle.
// - push_pc_i        in   XLEN             return address to push (call PC + 4).
// - restore_i        in   1                mispredict repair request.
// - restore_ckpt_i   in   ras_ckpt_t       checkpoint to restore.
// - ckpt_o           out  ras_ckpt_t       current state snapshot, sampled by the predictor per branch.
// - top_o            out  bmm_pkg::ras_t   {vld, ras_data}: predicted return target.
// - overflow_o       out  1                1-cycle pulse when a push overwrites the oldest valid entry.
// - underflow_o      out  1                1-cycle pulse when a pop occurs with count==0.
// BEHAVIOUR
// - State
//   - mem[DEPTH] of XLEN.
//   - tos: log2(DEPTH) bits; wraps modulo DEPTH.
//   - cnt: log2(DEPTH)+1 bits; range 0..DEPTH.
// - Outputs are combinational from registered state. No extra latency: an update at edge N is visible on top_o after edge N.
//   - top_o.vld = (cnt!=0); top_o.ras_data = mem[tos] when vld, else 0.
//   - ckpt_o = {tos, cnt, mem[tos]}.
// - Priority per cycle: rst (rst_ni==0) > flush_i > restore_i > push/pop. A lower-priority request in the same cycle is dropped.
// - Reset: tos=0, cnt=0, all mem=0, overflow_o=0, underflow_o=0. Reset asserted mid-operation discards the cycle's push/pop/restore.
// - flush_i: tos=0, cnt=0; mem is not cleared (stale data is masked by vld); no pulses.
// - restore_i:
//   - tos = ckpt.tos, cnt = ckpt.cnt.
//   - mem[ckpt.tos] = ckpt.top, repairing the top entry a wrong-path push overwrote.
//   - Deeper entries are not repaired (accepted inaccuracy).
// - push only:
//   - tos = tos+1 (wraps DEPTH-1 -> 0); mem[tos+1] = push_pc_i.
//   - cnt = min(cnt+1, DEPTH); overflow_o=1 if cnt==DEPTH before the push.
// - pop only:
//   - cnt>0: tos = tos-1 (wraps 0 -> DEPTH-1); cnt = cnt-1.
//   - cnt==0: no state change; underflow_o=1.
// - push & pop (tail call / ret+call in the same fetch group):
//   - mem[tos] = push_pc_i; tos unchanged.
//   - cnt = max(cnt,1); no pulses.
// - Idle: state held; pulses 0.
// - overflow_o and underflow_o are registered pulses, asserted the cycle after the causing edge, for exactly 1 cycle.
// STRUCTURE
// - bmm_pkg additions:
//   - localparam RAS_DEPTH = 8.
//   - typedef ras_ckpt_t {tos [$clog2(RAS_DEPTH)-1:0], cnt [$clog2(RAS_DEPTH):0], top [31:0]}.
//   - Existing ras_t {vld, ras_data} is reused for top_o.
// - No sub-module: storage is a flat register array with pointer arithmetic inline.
// - Single always_ff for state with sync reset, plus always_comb next-state logic.
// TESTING
// - Reset, then push 0x100, 0x200, 0x300
//   -> top_o={1,0x300}, cnt=3; then pop -> top_o={1,0x200}.
// - DEPTH=8: push 9 values 0x10..0x90
//   -> overflow_o pulses once after the 9th push.
//   -> 8 pops return 0x90..0x20; the next pop gives top_o.vld=0 and underflow_o=1.
// - Empty stack, push & pop with 0xAA in the same cycle
//   -> top_o={1,0xAA}, cnt=1, tos unchanged, no pulses.
// - Push 0x100, capture ckpt_o; push 0x500; pop; push 0x600; assert restore_i with the captured ckpt
//   -> top_o={1,0x100}, cnt=1.
// - flush_i, restore_i and push_i asserted in the same cycle
//   -> cnt=0, top_o.vld=0.
//   -> rst_ni=0 during a push -> next cycle all state 0, no pulses.
// - Pointer wrap: 20 pushes, 8 pops, 3 pushes (0xC1..0xC3)
//   -> top_o tracks the expected model every cycle.
//   -> Checked against a scoreboard model with a random push/pop/restore/flush stream, 10k cycles.

Source files
------------

// File: rtl/bmm_pkg.sv
// Branch/fetch predictor shared types: RAS depth, the top-of-stack prediction
// record and the checkpoint record the branch unit hands back on a mispredict.
package bmm_pkg;

    localparam int RAS_DEPTH = 8;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

    typedef struct packed {
        logic        vld;
        logic [31:0] ras_data;
    } ras_t;

    typedef struct packed {
        logic [RAS_PTR_W-1:0] tos;
        logic [RAS_PTR_W:0]   cnt;
        logic [31:0]          top;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_spec_ckpt_pkg.sv
// Local types for the checkpointed return address stack: the per-cycle operation
// after priority resolution, and the decoder that applies that priority.
package ras_spec_ckpt_pkg;

    typedef enum logic [2:0] {
        RAS_OP_IDLE    = 3'd0,
        RAS_OP_FLUSH   = 3'd1,
        RAS_OP_RESTORE = 3'd2,
        RAS_OP_PUSH    = 3'd3,
        RAS_OP_POP     = 3'd4,
        RAS_OP_REPLACE = 3'd5
    } ras_op_e;

    // Flush beats restore beats push/pop; losing requests are simply dropped.
    function automatic ras_op_e ras_decode(input logic flush,
                                           input logic restore,
                                           input logic push,
                                           input logic pop);
        ras_op_e op;
        op = RAS_OP_IDLE;
        if (flush) begin
            op = RAS_OP_FLUSH;
        end else if (restore) begin
            op = RAS_OP_RESTORE;
        end else if (push && pop) begin
            op = RAS_OP_REPLACE;
        end else if (push) begin
            op = RAS_OP_PUSH;
        end else if (pop) begin
            op = RAS_OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_spec_ckpt_if.sv
// Predictor-side bundle of the return address stack. Requests are single-cycle
// strobes with no backpressure: the stack accepts every request on the edge it is seen.
interface ras_spec_ckpt_if;
    import bmm_pkg::*;

    logic        flush_i;
    logic        push_i;
    logic        pop_i;
    logic [31:0] push_pc_i;
    logic        restore_i;
    ras_ckpt_t   restore_ckpt_i;
    ras_ckpt_t   ckpt_o;
    ras_t        top_o;
    logic        overflow_o;
    logic        underflow_o;

    modport master (
        output flush_i, push_i, pop_i, push_pc_i, restore_i, restore_ckpt_i,
        input  ckpt_o, top_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, push_i, pop_i, push_pc_i, restore_i, restore_ckpt_i,
        output ckpt_o, top_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/ras_spec_ckpt.sv
// Circular return address stack with overflow wrap, underflow detect and
// checkpoint/restore of {tos, cnt, top entry} for mispredict repair.
module ras_spec_ckpt
    import bmm_pkg::*;
    import ras_spec_ckpt_pkg::*;
#(
    parameter int DEPTH = bmm_pkg::RAS_DEPTH,
    parameter int XLEN  = 32
) (
    input logic           clk_i,
    input logic           rst_ni,
    ras_spec_ckpt_if.slave ras
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    if (DEPTH != bmm_pkg::RAS_DEPTH) begin : g_bad_depth
        $error("ras_spec_ckpt: DEPTH must equal bmm_pkg::RAS_DEPTH");
    end
    if (XLEN != 32) begin : g_bad_xlen
        $error("ras_spec_ckpt: XLEN must match the 32-bit ras_t/ras_ckpt_t payload");
    end

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [XLEN-1:0]  wr_data;
    ras_op_e          op;
    logic             top_vld;

    always_comb begin
        op      = ras_decode(ras.flush_i, ras.restore_i, ras.push_i, ras.pop_i);
        tos_d   = tos_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = tos_q;
        wr_data = ras.push_pc_i;

        unique case (op)
            RAS_OP_FLUSH: begin
                // Contents stay behind; cnt==0 masks them through top_o.vld.
                tos_d = '0;
                cnt_d = '0;
            end
            RAS_OP_RESTORE: begin
                // Only the checkpointed top entry is rewritten; deeper wrong-path damage stays.
                tos_d   = ras.restore_ckpt_i.tos;
                cnt_d   = ras.restore_ckpt_i.cnt;
                wr_en   = 1'b1;
                wr_idx  = ras.restore_ckpt_i.tos;
                wr_data = ras.restore_ckpt_i.top;
            end
            RAS_OP_PUSH: begin
                tos_d  = tos_q + PTR_ONE;
                wr_en  = 1'b1;
                wr_idx = tos_q + PTR_ONE;
                if (cnt_q == CNT_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RAS_OP_POP: begin
                if (cnt_q == '0) begin
                    unf_d = 1'b1;
                end else begin
                    tos_d = tos_q - PTR_ONE;
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RAS_OP_REPLACE: begin
                // Return then call in one fetch group: the new return address replaces the top.
                wr_en  = 1'b1;
                wr_idx = tos_q;
                if (cnt_q == '0) begin
                    cnt_d = CNT_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tos_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (wr_en) begin
                mem_q[wr_idx] <= wr_data;
            end
        end
    end

    assign top_vld = (cnt_q != '0);

    assign ras.top_o       = '{vld: top_vld, ras_data: (top_vld ? mem_q[tos_q] : '0)};
    assign ras.ckpt_o      = '{tos: tos_q, cnt: cnt_q, top: mem_q[tos_q]};
    assign ras.overflow_o  = ovf_q;
    assign ras.underflow_o = unf_q;

endmodule

// File: tb/tb_ras_spec_ckpt.sv
// Self-checking bench for ras_spec_ckpt: directed scenarios plus a long random
// push/pop/restore/flush/reset stream checked against a behavioural stack model.
module tb_ras_spec_ckpt;
  import bmm_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;

  ras_spec_ckpt_if ras();

  ras_spec_ckpt #(.DEPTH(8), .XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .ras    (ras)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [31:0] m_mem [8];
  int          m_tos;
  int          m_cnt;
  logic        m_ovf;
  logic        m_unf;
  logic [31:0] exp_q [$];

  task automatic model_step(input logic rstn, input logic flush, input logic restore,
                            input ras_ckpt_t ck, input logic push, input logic pop,
                            input logic [31:0] pc);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (!rstn) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
      m_tos = 0;
      m_cnt = 0;
    end else if (flush) begin
      m_tos = 0;
      m_cnt = 0;
    end else if (restore) begin
      m_tos = int'(ck.tos);
      m_cnt = int'(ck.cnt);
      m_mem[m_tos] = ck.top;
    end else if (push && pop) begin
      m_mem[m_tos] = pc;
      if (m_cnt == 0) m_cnt = 1;
    end else if (push) begin
      m_ovf = (m_cnt == 8);
      m_tos = (m_tos + 1) % 8;
      m_mem[m_tos] = pc;
      if (m_cnt < 8) m_cnt = m_cnt + 1;
    end else if (pop) begin
      if (m_cnt == 0) begin
        m_unf = 1'b1;
      end else begin
        m_tos = (m_tos + 7) % 8;
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  function automatic ras_t model_top();
    ras_t t;
    t.vld = (m_cnt != 0);
    t.ras_data = t.vld ? m_mem[m_tos] : 32'h0;
    return t;
  endfunction

  function automatic ras_ckpt_t model_ckpt();
    ras_ckpt_t c;
    c.tos = 3'(m_tos);
    c.cnt = 4'(m_cnt);
    c.top = m_mem[m_tos];
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic rstn, input logic flush, input logic restore,
                             input ras_ckpt_t ck, input logic push, input logic pop,
                             input logic [31:0] pc);
    rst_ni             = rstn;
    ras.flush_i        = flush;
    ras.restore_i      = restore;
    ras.restore_ckpt_i = ck;
    ras.push_i         = push;
    ras.pop_i          = pop;
    ras.push_pc_i      = pc;
    @(posedge clk);
    model_step(rstn, flush, restore, ck, push, pop, pc);
    #1;
    rst_ni             = 1'b1;
    ras.flush_i        = 1'b0;
    ras.restore_i      = 1'b0;
    ras.restore_ckpt_i = '0;
    ras.push_i         = 1'b0;
    ras.pop_i          = 1'b0;
    ras.push_pc_i      = 32'h0;
  endtask

  task automatic do_reset();             drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 32'h0); endtask
  task automatic do_idle();              drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 32'h0); endtask
  task automatic do_push(input logic [31:0] pc); drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, pc); endtask
  task automatic do_pop();               drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h0); endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ras_t      e_top;
    ras_ckpt_t e_ck;
    do_reset();
    do_reset();
    e_top = '{vld: 1'b0, ras_data: 32'h0};
    e_ck  = '{tos: 3'd0, cnt: 4'd0, top: 32'h0};
    total_cnt++; if (ras.top_o !== e_top) $display("FAIL reset_top: got %h required %h", ras.top_o, e_top); else pass_cnt++;
    total_cnt++; if (ras.ckpt_o !== e_ck) $display("FAIL reset_ckpt: got %h required %h", ras.ckpt_o, e_ck); else pass_cnt++;
    total_cnt++; if (ras.overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b required 0", ras.overflow_o); else pass_cnt++;
    total_cnt++; if (ras.underflow_o !== 1'b0) $display("FAIL reset_unf: got %b required 0", ras.underflow_o); else pass_cnt++;
  endtask

  task automatic test_push_pop();
    ras_t e_top;
    do_reset();
    do_push(32'h100);
    do_push(32'h200);
    do_push(32'h300);
    e_top = '{vld: 1'b1, ras_data: 32'h300};
    total_cnt++; if (ras.top_o !== e_top) $display("FAIL push3_top: got %h required %h", ras.top_o, e_top); else pass_cnt++;
    total_cnt++; if (ras.ckpt_o.cnt !== 4'd3) $display("FAIL push3_cnt: got %0d required 3", ras.ckpt_o.cnt); else pass_cnt++;
    total_cnt++; if (ras.ckpt_o.tos !== 3'd3) $display("FAIL push3_tos: got %0d required 3", ras.ckpt_o.tos); else pass_cnt++;
    do_pop();
    e_top = '{vld: 1'b1, ras_data: 32'h200};
    total_cnt++; if (ras.top_o !== e_top) $display("FAIL pop_top: got %h required %h", ras.top_o, e_top); else pass_cnt++;
    total_cnt++; if (ras.ckpt_o.cnt !== 4'd2) $display("FAIL pop_cnt: got %0d required 2", ras.ckpt_o.cnt); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [31:0] val;
    logic [31:0] exp_v;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      val = 32'h10 * (i + 1);
      do_push(val);
      exp_q.push_front(val);
      total_cnt++;
      if (ras.overflow_o !== (i == 8)) $display("FAIL ovf_push%0d: got %b required %b", i + 1, ras.overflow_o, (i == 8));
      else pass_cnt++;
    end
    total_cnt++; if (ras.ckpt_o.cnt !== 4'd8) $display("FAIL ovf_cnt: got %0d required 8", ras.ckpt_o.cnt); else pass_cnt++;
    do_idle();
    total_cnt++; if (ras.overflow_o !== 1'b0) $display("FAIL ovf_one_cycle: got %b required 0", ras.overflow_o); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (ras.top_o !== '{vld: 1'b1, ras_data: exp_v}) $display("FAIL pop%0d_value: got %h required 1_%h", k, ras.top_o, exp_v);
      else pass_cnt++;
      do_pop();
      total_cnt++;
      if (ras.underflow_o !== 1'b0) $display("FAIL pop%0d_unf: got %b required 0", k, ras.underflow_o); else pass_cnt++;
    end
    total_cnt++; if (ras.top_o.vld !== 1'b0) $display("FAIL empty_vld: got %b required 0", ras.top_o.vld); else pass_cnt++;
    do_pop();
    total_cnt++; if (ras.underflow_o !== 1'b1) $display("FAIL unf_pulse: got %b required 1", ras.underflow_o); else pass_cnt++;
    total_cnt++; if (ras.top_o.vld !== 1'b0) $display("FAIL unf_vld: got %b required 0", ras.top_o.vld); else pass_cnt++;
    do_idle();
    total_cnt++; if (ras.underflow_o !== 1'b0) $display("FAIL unf_one_cycle: got %b required 0", ras.underflow_o); else pass_cnt++;
  endtask

  task automatic test_push_pop_same();
    ras_t e_top;
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hAA);
    e_top = '{vld: 1'b1, ras_data: 32'hAA};
    total_cnt++; if (ras.top_o !== e_top) $display("FAIL pushpop_top: got %h required %h", ras.top_o, e_top); else pass_cnt++;
    total_cnt++; if (ras.ckpt_o.cnt !== 4'd1) $display("FAIL pushpop_cnt: got %0d required 1", ras.ckpt_o.cnt); else pass_cnt++;
    total_cnt++; if (ras.ckpt_o.tos !== 3'd0) $display("FAIL pushpop_tos: got %0d required 0", ras.ckpt_o.tos); else pass_cnt++;
    total_cnt++; if ({ras.overflow_o, ras.underflow_o} !== 2'b00) $display("FAIL pushpop_pulses: got %b required 00", {ras.overflow_o, ras.underflow_o}); else pass_cnt++;
  endtask

  task automatic test_restore();
    ras_ckpt_t ck;
    ras_t      e_top;
    do_reset();
    do_push(32'h100);
    ck = '{tos: 3'd1, cnt: 4'd1, top: 32'h100};
    total_cnt++; if (ras.ckpt_o !== ck) $display("FAIL ckpt_capture: got %h required %h", ras.ckpt_o, ck); else pass_cnt++;
    do_push(32'h500);
    do_pop();
    do_push(32'h600);
    drive_cycle(1'b1, 1'b0, 1'b1, ck, 1'b0, 1'b0, 32'h0);
    e_top = '{vld: 1'b1, ras_data: 32'h100};
    total_cnt++; if (ras.top_o !== e_top) $display("FAIL restore_top: got %h required %h", ras.top_o, e_top); else pass_cnt++;
    total_cnt++; if (ras.ckpt_o.cnt !== 4'd1) $display("FAIL restore_cnt: got %0d required 1", ras.ckpt_o.cnt); else pass_cnt++;
    // Restore repairs an overwritten top entry.
    drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h777);
    drive_cycle(1'b1, 1'b0, 1'b1, ck, 1'b0, 1'b0, 32'h0);
    total_cnt++; if (ras.top_o !== e_top) $display("FAIL restore_repair: got %h required %h", ras.top_o, e_top); else pass_cnt++;
  endtask

  task automatic test_priority();
    ras_ckpt_t ck;
    do_reset();
    do_push(32'h11);
    do_push(32'h22);
    ck = '{tos: 3'd2, cnt: 4'd2, top: 32'h22};
    drive_cycle(1'b1, 1'b1, 1'b1, ck, 1'b1, 1'b0, 32'h33);
    total_cnt++; if (ras.ckpt_o.cnt !== 4'd0) $display("FAIL flush_cnt: got %0d required 0", ras.ckpt_o.cnt); else pass_cnt++;
    total_cnt++; if (ras.top_o.vld !== 1'b0) $display("FAIL flush_vld: got %b required 0", ras.top_o.vld); else pass_cnt++;
    total_cnt++; if (ras.ckpt_o.tos !== 3'd0) $display("FAIL flush_tos: got %0d required 0", ras.ckpt_o.tos); else pass_cnt++;
    // Restore beats push.
    drive_cycle(1'b1, 1'b0, 1'b1, ck, 1'b1, 1'b0, 32'h44);
    total_cnt++; if (ras.top_o !== '{vld: 1'b1, ras_data: 32'h22}) $display("FAIL restore_over_push: got %h required 1_00000022", ras.top_o); else pass_cnt++;
    do_push(32'h55);
    drive_cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h66);
    drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h77);
    total_cnt++; if (ras.ckpt_o !== '0) $display("FAIL rst_ckpt: got %h required 0", ras.ckpt_o); else pass_cnt++;
    total_cnt++; if (ras.top_o !== '0) $display("FAIL rst_top: got %h required 0", ras.top_o); else pass_cnt++;
    total_cnt++; if ({ras.overflow_o, ras.underflow_o} !== 2'b00) $display("FAIL rst_pulses: got %b required 00", {ras.overflow_o, ras.underflow_o}); else pass_cnt++;
  endtask

  task automatic test_pointer_wrap();
    ras_t e_top;
    int   errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 31; i++) begin
      if (i < 20)      do_push(32'h1000 + 32'(i));
      else if (i < 28) do_pop();
      else             do_push(32'hC1 + 32'(i - 28));
      e_top = model_top();
      total_cnt++;
      if (ras.top_o !== e_top) begin
        $display("FAIL wrap_step%0d: got %h required %h", i, ras.top_o, e_top);
        errs++;
      end else pass_cnt++;
    end
    total_cnt++;
    if (ras.top_o !== '{vld: 1'b1, ras_data: 32'hC3}) $display("FAIL wrap_final: got %h required 1_000000c3", ras.top_o);
    else pass_cnt++;
  endtask

  task automatic test_random();
    ras_ckpt_t snap;
    ras_ckpt_t ck;
    ras_t      e_top;
    ras_ckpt_t e_ck;
    int        r;
    logic      rstn, flush, restore, push, pop;
    do_reset();
    snap = model_ckpt();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r       = int'($urandom_range(0, 199));
      rstn    = (r != 0);
      flush   = (r >= 1 && r < 6);
      restore = (r >= 6 && r < 18);
      push    = ($urandom_range(0, 99) < 55);
      pop     = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 3) == 0) begin
        ck.tos = 3'($urandom_range(0, 7));
        ck.cnt = 4'($urandom_range(0, 8));
        ck.top = $urandom;
      end else begin
        ck = snap;
      end
      if ($urandom_range(0, 7) == 0) snap = model_ckpt();
      drive_cycle(rstn, flush, restore, ck, push, pop, $urandom);
      e_top = model_top();
      e_ck  = model_ckpt();
      total_cnt++; if (ras.top_o !== e_top) $display("FAIL rnd%0d_top: got %h required %h", cyc, ras.top_o, e_top); else pass_cnt++;
      total_cnt++; if (ras.ckpt_o !== e_ck) $display("FAIL rnd%0d_ckpt: got %h required %h", cyc, ras.ckpt_o, e_ck); else pass_cnt++;
      total_cnt++; if (ras.overflow_o !== m_ovf) $display("FAIL rnd%0d_ovf: got %b required %b", cyc, ras.overflow_o, m_ovf); else pass_cnt++;
      total_cnt++; if (ras.underflow_o !== m_unf) $display("FAIL rnd%0d_unf: got %b required %b", cyc, ras.underflow_o, m_unf); else pass_cnt++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    ras.flush_i        = 1'b0;
    ras.restore_i      = 1'b0;
    ras.restore_ckpt_i = '0;
    ras.push_i         = 1'b0;
    ras.pop_i          = 1'b0;
    ras.push_pc_i      = 32'h0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_push_pop_same();
    test_restore();
    test_priority();
    test_pointer_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
